// File: rtl/mult_accum.sv
// mult_accum: accumulates LEN unsigned products into a saturating sum and hands
// the sum, product count and saturation flag downstream over valid/ready.
module mult_accum #(
    parameter int PROD_W = 4,
    parameter int ACC_W = 8,
    parameter int LEN = 4,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              flush,
    output logic [ACC_W-1:0]  sum_out,
    output logic [CNT_W-1:0]  sum_cnt,
    output logic              sum_sat,
    output logic              sum_valid,
    input  logic              sum_ready
);
    typedef enum logic {ACC, HOLD} state_t;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    state_t state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ACC_W:0] sum_wide;
    logic sat_acc, sat_nxt, accept, close, drain;
    always_comb begin
        prod_ready = state == ACC && !rst;
        accept = prod_ready && prod_valid;
        sum_wide = {1'b0, acc} + (ACC_W + 1)'(prod_in);
        acc_nxt = !accept ? acc : sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
        cnt_nxt = accept ? cnt + 1'b1 : cnt;
        sat_nxt = sat_acc | (accept & sum_wide[ACC_W]);
        // flush only closes a burst that holds at least one product
        close = state == ACC && ((accept && cnt_nxt == CNT_W'(LEN)) || (flush && (cnt != '0 || accept)));
        drain = state == HOLD && sum_valid && sum_ready;
        state_nxt = close ? HOLD : drain ? ACC : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            sat_acc <= 1'b0;
            sum_out <= '0;
            sum_cnt <= '0;
            sum_sat <= 1'b0;
            sum_valid <= 1'b0;
        end else if (close) begin
            acc <= '0;
            cnt <= '0;
            sat_acc <= 1'b0;
            sum_out <= acc_nxt;
            sum_cnt <= cnt_nxt;
            sum_sat <= sat_nxt;
            sum_valid <= 1'b1;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            sat_acc <= sat_nxt;
            if (drain) sum_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mult_accum.sv
// tb_mult_accum: directed scenarios plus random traffic against a burst-level reference model.
module tb_mult_accum;
    localparam int PROD_W = 4;
    localparam int ACC_W = 5;
    localparam int LEN = 4;
    localparam int CNT_W = $clog2(LEN + 1);
    localparam int unsigned MAXV = (1 << ACC_W) - 1;
    logic clk = 0, rst = 1, prod_valid = 0, flush = 0, sum_ready = 0;
    logic [PROD_W-1:0] prod_in = 0;
    logic prod_ready, sum_sat, sum_valid;
    logic [ACC_W-1:0] sum_out;
    logic [CNT_W-1:0] sum_cnt;
    int n_chk = 0, n_fail = 0;
    int unsigned q[$];
    bit mv = 0, msat = 0;
    int unsigned mout = 0, mcnt = 0;
    mult_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .flush(flush), .sum_out(sum_out), .sum_cnt(sum_cnt),
        .sum_sat(sum_sat), .sum_valid(sum_valid), .sum_ready(sum_ready)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int unsigned obs, input int unsigned want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
        end
    endtask
    task automatic peek(input string tag, input int unsigned o, input int unsigned c, input int unsigned s, input int unsigned v);
        chk({tag, ".sum_out"}, sum_out, o);
        chk({tag, ".sum_cnt"}, sum_cnt, c);
        chk({tag, ".sum_sat"}, sum_sat, s);
        chk({tag, ".sum_valid"}, sum_valid, v);
    endtask
    // one clock: drive, check registered outputs vs model, advance model on the edge
    task automatic cycle(input bit pv, input int unsigned pin, input bit fl, input bit sr, input bit r);
        int unsigned total;
        rst = r; prod_valid = pv; prod_in = PROD_W'(pin); flush = fl; sum_ready = sr;
        @(negedge clk);
        chk("prod_ready", prod_ready, !r && !mv);
        chk("sum_valid", sum_valid, mv);
        chk("sum_out", sum_out, mout);
        chk("sum_cnt", sum_cnt, mcnt);
        chk("sum_sat", sum_sat, msat);
        if (r) begin
            q.delete(); mv = 0; mout = 0; mcnt = 0; msat = 0;
        end else if (mv) begin
            if (sr) mv = 0;
        end else begin
            if (pv) q.push_back(pin % (1 << PROD_W));
            if (q.size() == LEN || (fl && q.size() > 0)) begin
                total = 0;
                foreach (q[i]) total += q[i];
                mout = total > MAXV ? MAXV : total;
                msat = total > MAXV;
                mcnt = q.size();
                mv = 1;
                q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic feed(input int unsigned a, input int unsigned b, input int unsigned c, input int unsigned d, input bit sr);
        cycle(1, a, 0, sr, 0); cycle(1, b, 0, sr, 0); cycle(1, c, 0, sr, 0); cycle(1, d, 0, sr, 0);
    endtask
    initial begin
        int unsigned vpat[7] = '{1, 0, 0, 1, 0, 1, 1};
        int unsigned dpat[7] = '{2, 13, 11, 3, 9, 1, 4};
        repeat (2) @(posedge clk);
        #1;
        peek("reset", 0, 0, 0, 0);
        feed(3, 5, 7, 9, 1);
        peek("burst24", 24, 4, 0, 1);
        cycle(0, 0, 0, 1, 0);
        peek("after_hs", 24, 4, 0, 0);
        chk("ready_back", prod_ready, 1);
        feed(1, 2, 3, 4, 0);
        for (int i = 0; i < 6; i++) cycle(1, 5 + i, 0, 0, 0);
        peek("stall10", 10, 4, 0, 1);
        chk("stall_ready", prod_ready, 0);
        cycle(1, 9, 0, 1, 0);
        feed(15, 15, 15, 1, 1);
        peek("sat", 31, 4, 1, 1);
        cycle(0, 0, 0, 1, 0);
        feed(1, 1, 1, 1, 1);
        peek("sat_clear", 4, 4, 0, 1);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 6, 0, 1, 0); cycle(1, 2, 0, 1, 0); cycle(0, 0, 1, 1, 0);
        peek("flush8", 8, 2, 0, 1);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 0);
        peek("flush_empty", 8, 2, 0, 0);
        cycle(1, 6, 0, 1, 0); cycle(1, 2, 0, 1, 0); cycle(1, 4, 1, 1, 0);
        peek("flush12", 12, 3, 0, 1);
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) cycle(vpat[i][0], dpat[i], 0, 1, 0);
        peek("bubbles", 10, 4, 0, 1);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 5, 0, 1, 0); cycle(1, 2, 0, 1, 0); cycle(0, 0, 0, 1, 1);
        feed(1, 1, 1, 1, 0);
        peek("post_rst", 4, 4, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        peek("rst_hold", 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
